// File: rtl/sv_window_monitor.sv
// sv_window_monitor: NUM_WIN programmable inclusive windows over a sample
// stream. Each window has a registered in-range flag and an alarm that
// flips only after PERSIST consecutive disagreeing valid samples.
// Optional hysteresis on the alarm-clear test is compiled in with the
// macro WINMON_HYST_EN. With the macro undefined, HYST has no effect.

// One window: bounds, enable, in-range flag, persistence counter, alarm.
module sv_window_monitor_win #(
   parameter int WIDTH   = 4,
   parameter int PERSIST = 2,
   parameter int MARGIN  = 0
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             cfg_wr,
   input  logic [WIDTH-1:0] cfg_lo,
   input  logic [WIDTH-1:0] cfg_hi,
   input  logic             data_valid,
   input  logic [WIDTH-1:0] data,
   output logic             in_range,
   output logic             alarm,
   output logic             alarm_rise
);
   localparam int CW = (PERSIST > 1) ? $clog2(PERSIST + 1) : 1;
   localparam logic [CW-1:0] CNT_LAST = CW'(PERSIST - 1);
   localparam logic [63:0]   MAXV     = (64'd1 << WIDTH) - 64'd1;
   localparam logic [63:0]   MARG     = 64'(MARGIN);

   logic             en;
   logic [WIDTH-1:0] lo, hi;
   logic [CW-1:0]    cnt;
   logic             match, wide_match, t;
   logic [63:0]      lo64, hi64, d64, wlo, whi;

   // Exact and widened window tests; the widened bounds saturate, never wrap.
   always_comb begin
      lo64       = 64'(lo);
      hi64       = 64'(hi);
      d64        = 64'(data);
      wlo        = (lo64 >= MARG) ? (lo64 - MARG) : 64'd0;
      whi        = (hi64 + MARG > MAXV) ? MAXV : (hi64 + MARG);
      match      = en && (lo <= data) && (data <= hi);
      wide_match = en && (wlo <= d64) && (d64 <= whi);
      t          = alarm ? wide_match : match;
   end

   // Config write wins over a same-cycle sample; invalid cycles hold state.
   always_ff @(posedge clk) begin
      if (rst) begin
         en         <= 1'b0;
         lo         <= '0;
         hi         <= '0;
         cnt        <= '0;
         in_range   <= 1'b0;
         alarm      <= 1'b0;
         alarm_rise <= 1'b0;
      end else begin
         alarm_rise <= 1'b0;
         if (cfg_wr) begin
            en       <= 1'b1;
            lo       <= cfg_lo;
            hi       <= cfg_hi;
            cnt      <= '0;
            in_range <= 1'b0;
            alarm    <= 1'b0;
         end else if (data_valid) begin
            in_range <= match;
            if (t == alarm) begin
               cnt <= '0;
            end else if (cnt == CNT_LAST) begin
               alarm      <= ~alarm;
               alarm_rise <= ~alarm;
               cnt        <= '0;
            end else begin
               cnt <= cnt + 1'b1;
            end
         end
      end
   end
endmodule

// Top: validates config writes and fans the sample out to every window.
module sv_window_monitor #(
   parameter int WIDTH   = 4,
   parameter int NUM_WIN = 3,
   parameter int PERSIST = 2,
   parameter int HYST    = 1,
   localparam int IDX_W  = (NUM_WIN > 1) ? $clog2(NUM_WIN) : 1
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               cfg_we,
   input  logic [IDX_W-1:0]   cfg_idx,
   input  logic [WIDTH-1:0]   cfg_lo,
   input  logic [WIDTH-1:0]   cfg_hi,
   input  logic               data_valid,
   input  logic [WIDTH-1:0]   data,
   output logic [NUM_WIN-1:0] in_range,
   output logic [NUM_WIN-1:0] alarm,
   output logic [NUM_WIN-1:0] alarm_rise,
   output logic               cfg_err
);
`ifdef WINMON_HYST_EN
   localparam int MARGIN = HYST;
`else
   // Margin collapses to zero so the alarm test is the exact window.
   localparam int MARGIN = HYST * 0;
`endif

   logic               cfg_ok;
   logic [NUM_WIN-1:0] cfg_wr;

   // A write is accepted only for an existing window with ordered bounds.
   always_comb begin
      cfg_ok = cfg_we && (32'(cfg_idx) < NUM_WIN) && (cfg_lo <= cfg_hi);
      cfg_wr = '0;
      for (int i = 0; i < NUM_WIN; i++)
         cfg_wr[i] = cfg_ok && (32'(cfg_idx) == i);
   end

   // Rejected writes pulse cfg_err for one cycle.
   always_ff @(posedge clk) begin
      if (rst) cfg_err <= 1'b0;
      else     cfg_err <= cfg_we && !cfg_ok;
   end

   for (genvar i = 0; i < NUM_WIN; i++) begin : g_win
      sv_window_monitor_win #(
         .WIDTH  (WIDTH),
         .PERSIST(PERSIST),
         .MARGIN (MARGIN)
      ) u_win (
         .clk        (clk),
         .rst        (rst),
         .cfg_wr     (cfg_wr[i]),
         .cfg_lo     (cfg_lo),
         .cfg_hi     (cfg_hi),
         .data_valid (data_valid),
         .data       (data),
         .in_range   (in_range[i]),
         .alarm      (alarm[i]),
         .alarm_rise (alarm_rise[i])
      );
   end
endmodule

// File: tb/tb_sv_window_monitor.sv
// Self-checking bench for sv_window_monitor (defaults WIDTH=4, NUM_WIN=3,
// PERSIST=2, HYST=1). A behavioural model pushes expected outputs when a
// step is driven; they are popped and compared after the clock edge.
module tb_sv_window_monitor;
   localparam int W = 4, NW = 3, P = 2, HY = 1, IW = 2;

   logic          clk = 1'b0;
   logic          rst, cfg_we, data_valid, cfg_err;
   logic [IW-1:0] cfg_idx;
   logic [W-1:0]  cfg_lo, cfg_hi, data;
   logic [NW-1:0] in_range, alarm, alarm_rise;

   int checks = 0, failures = 0;

   typedef struct packed {
      logic [NW-1:0] ir;
      logic [NW-1:0] al;
      logic [NW-1:0] rise;
      logic          err;
   } exp_t;
   exp_t q[$];

   // Model state
   logic    m_en[NW];
   int      m_lo[NW], m_hi[NW], m_cnt[NW];
   logic    m_ir[NW], m_al[NW];

`ifdef WINMON_HYST_EN
   localparam bit HYST_ON = 1'b1;
`else
   localparam bit HYST_ON = 1'b0;
`endif

   sv_window_monitor #(.WIDTH(W), .NUM_WIN(NW), .PERSIST(P), .HYST(HY)) dut (
      .clk(clk), .rst(rst), .cfg_we(cfg_we), .cfg_idx(cfg_idx),
      .cfg_lo(cfg_lo), .cfg_hi(cfg_hi), .data_valid(data_valid), .data(data),
      .in_range(in_range), .alarm(alarm), .alarm_rise(alarm_rise),
      .cfg_err(cfg_err));

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Drive one cycle, update the model, then compare after the edge.
   task automatic step(input logic r, input logic we, input int idx, input int lo,
                       input int hi, input logic v, input int d);
      exp_t e;
      logic ok, mt, t;
      int wl, wh;
      e = '0;
      if (r) begin
         for (int i = 0; i < NW; i++) begin
            m_en[i] = 0; m_lo[i] = 0; m_hi[i] = 0; m_cnt[i] = 0;
            m_ir[i] = 0; m_al[i] = 0;
         end
      end else begin
         ok = we && idx < NW && lo <= hi;
         e.err = we && !ok;
         for (int i = 0; i < NW; i++) begin
            if (ok && idx == i) begin
               m_en[i] = 1; m_lo[i] = lo; m_hi[i] = hi; m_cnt[i] = 0;
               m_ir[i] = 0; m_al[i] = 0;
            end else if (v) begin
               mt = m_en[i] && d >= m_lo[i] && d <= m_hi[i];
               t = mt;
               if (HYST_ON && m_al[i]) begin
                  wl = m_lo[i] - HY; if (wl < 0) wl = 0;
                  wh = m_hi[i] + HY; if (wh > 15) wh = 15;
                  t = m_en[i] && d >= wl && d <= wh;
               end
               m_ir[i] = mt;
               if (t == m_al[i]) m_cnt[i] = 0;
               else if (m_cnt[i] == P - 1) begin
                  m_al[i] = !m_al[i];
                  e.rise[i] = m_al[i];
                  m_cnt[i] = 0;
               end else m_cnt[i]++;
            end
         end
      end
      for (int i = 0; i < NW; i++) begin
         e.ir[i] = m_ir[i];
         e.al[i] = m_al[i];
      end
      q.push_back(e);
      rst = r; cfg_we = we; cfg_idx = IW'(idx); cfg_lo = W'(lo); cfg_hi = W'(hi);
      data_valid = v; data = W'(d);
      @(posedge clk); #1;
      if (q.size() == 0) begin
         chk("queue_empty", 32'd1, 32'd0);
      end else begin
         e = q.pop_front();
         chk("in_range", 32'(in_range), 32'(e.ir));
         chk("alarm", 32'(alarm), 32'(e.al));
         chk("alarm_rise", 32'(alarm_rise), 32'(e.rise));
         chk("cfg_err", 32'(cfg_err), 32'(e.err));
      end
   endtask

   task automatic smp(input int d);
      step(0, 0, 0, 0, 0, 1, d);
   endtask

   task automatic wr(input int idx, input int lo, input int hi);
      step(0, 1, idx, lo, hi, 0, 0);
   endtask

   initial begin
      rst = 1; cfg_we = 0; cfg_idx = '0; cfg_lo = '0; cfg_hi = '0;
      data_valid = 0; data = '0;
      // 1. reset, sweep with no windows, reset mid-sweep
      step(1, 0, 0, 0, 0, 0, 0);
      step(1, 1, 0, 3, 7, 1, 5);
      chk("reset_outputs", {in_range, alarm, alarm_rise, cfg_err}, 32'd0);
      for (int d = 0; d < 16; d++) begin
         if (d == 8) step(1, 0, 0, 0, 0, 1, d);
         else smp(d);
      end
      // 2. two windows, full sweep
      wr(0, 3, 7);
      wr(2, 10, 15);
      for (int d = 0; d < 16; d++) begin
         smp(d);
         if (d == 4) chk("p2_rise_w0", {alarm[0], alarm_rise[0]}, 32'h3);
         if (d == 9) chk("p2_fall_w0", alarm[0], HYST_ON ? 32'd1 : 32'd0);
         if (d == 11) chk("p2_rise_w2", alarm[2], 32'd1);
      end
      // 3. rejected and accepted writes
      wr(1, 9, 2);
      chk("p3_err_order", cfg_err, 32'd1);
      wr(3, 0, 1);
      chk("p3_err_idx", cfg_err, 32'd1);
      smp(5);
      chk("p3_w1_disabled", in_range[1], 32'd0);
      wr(1, 5, 5);
      chk("p3_no_err", cfg_err, 32'd0);
      smp(5); smp(5);
      chk("p3_alarm_w1", alarm[1], 32'd1);
      // 4. invalid gap does not break the run
      wr(0, 3, 7);
      smp(5);
      for (int k = 0; k < 3; k++) step(0, 0, 0, 0, 0, 0, 9);
      chk("p4_hold", {in_range[0], alarm[0]}, 32'h2);
      smp(5);
      chk("p4_rise", alarm[0], 32'd1);
      // 5. alternating samples never raise alarm
      wr(0, 3, 7);
      smp(5); smp(8); smp(5); smp(8);
      chk("p5_no_alarm", alarm[0], 32'd0);
      // 6. hysteresis / no hysteresis
      smp(5); smp(5);
      chk("p6_alarm_set", alarm[0], 32'd1);
      smp(8); smp(8);
      chk("p6_after_88", alarm[0], HYST_ON ? 32'd1 : 32'd0);
      smp(9); smp(9);
      chk("p6_after_99", alarm[0], 32'd0);
      // boundaries: full-range and zero-width windows, write+sample same cycle
      wr(1, 0, 15);
      smp(0); smp(15); smp(0);
      wr(2, 0, 0);
      step(0, 1, 1, 4, 6, 1, 0);
      smp(0); smp(15); smp(15);
      // randomised traffic against the model
      for (int k = 0; k < 300; k++) begin
         if ($urandom_range(0, 9) == 0)
            step(0, 1, $urandom_range(0, 3), $urandom_range(0, 15),
                 $urandom_range(0, 15), $urandom_range(0, 1), $urandom_range(0, 15));
         else if ($urandom_range(0, 99) == 0)
            step(1, 0, 0, 0, 0, 1, 0);
         else
            step(0, 0, 0, 0, 0, $urandom_range(0, 3) != 0, $urandom_range(0, 15));
      end
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
